// File: rtl/mem_bus_arbiter.sv
// Two-requester (icache/dcache) arbiter onto a single memory port.
// Round-robin with a hold-on-refusal lock, and load tags steered back to their owner.
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int XLEN            = 32,
  parameter int SIZE_W          = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ic_command,
  input  logic [XLEN-1:0]   ic_addr,
  input  logic [63:0]       ic_data,
  input  logic [SIZE_W-1:0] ic_size,
  input  logic [1:0]        dc_command,
  input  logic [XLEN-1:0]   dc_addr,
  input  logic [63:0]       dc_data,
  input  logic [SIZE_W-1:0] dc_size,
  output logic [3:0]        ic_response,
  output logic [3:0]        dc_response,
  output logic [3:0]        ic_tag,
  output logic [3:0]        dc_tag,
  output logic [63:0]       ret_data,
  output logic [1:0]        proc2mem_command,
  output logic [XLEN-1:0]   proc2mem_addr,
  output logic [63:0]       proc2mem_data,
  output logic [SIZE_W-1:0] proc2mem_size,
  input  logic [3:0]        mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [3:0]        mem2proc_tag,
  output logic              stray_tag
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);

  // Owner bit: 0 = icache, 1 = dcache. Entry 0 is never written (tag 0 means none).
  logic [15:0] r_valid;
  logic [15:0] r_owner;
  logic [3:0]  r_ic_cnt;
  logic [3:0]  r_dc_cnt;
  logic        r_last_grant;
  logic        r_locked;
  logic        r_lock_owner;
  logic        r_stray;

  logic w_ic_elig, w_dc_elig;
  logic w_gnt_valid, w_gnt_dc;
  logic w_accept, w_load_acc;
  logic w_ret_valid, w_ret_dc;

  function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [3:0] res;
    res = cnt;
    if (inc && !dec && (cnt < MAX_CNT)) res = cnt + 4'd1;
    else if (dec && !inc && (cnt != 4'd0)) res = cnt - 4'd1;
    else res = cnt;
    return res;
  endfunction

  assign w_ic_elig = (ic_command != BUS_NONE) && !((ic_command == BUS_LOAD) && (r_ic_cnt == MAX_CNT));
  assign w_dc_elig = (dc_command != BUS_NONE) && !((dc_command == BUS_LOAD) && (r_dc_cnt == MAX_CNT));

  // Grant selection: a live lock overrides round-robin.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_dc    = 1'b0;
    if (r_locked && (r_lock_owner ? w_dc_elig : w_ic_elig)) begin
      w_gnt_valid = 1'b1;
      w_gnt_dc    = r_lock_owner;
    end else if (w_ic_elig && w_dc_elig) begin
      w_gnt_valid = 1'b1;
      w_gnt_dc    = ~r_last_grant;
    end else if (w_ic_elig) begin
      w_gnt_valid = 1'b1;
      w_gnt_dc    = 1'b0;
    end else if (w_dc_elig) begin
      w_gnt_valid = 1'b1;
      w_gnt_dc    = 1'b1;
    end else begin
      w_gnt_valid = 1'b0;
      w_gnt_dc    = 1'b0;
    end
  end

  // Forward the granted requester's command onto the memory port.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = 64'd0;
    proc2mem_size    = '0;
    if (w_gnt_valid && w_gnt_dc) begin
      proc2mem_command = dc_command;
      proc2mem_addr    = dc_addr;
      proc2mem_data    = dc_data;
      proc2mem_size    = dc_size;
    end else if (w_gnt_valid) begin
      proc2mem_command = ic_command;
      proc2mem_addr    = ic_addr;
      proc2mem_data    = ic_data;
      proc2mem_size    = ic_size;
    end else begin
      proc2mem_command = BUS_NONE;
    end
  end

  assign w_accept    = w_gnt_valid && (mem2proc_response != 4'd0);
  assign w_load_acc  = w_accept && (proc2mem_command == BUS_LOAD);
  assign ic_response = (w_gnt_valid && !w_gnt_dc) ? mem2proc_response : 4'd0;
  assign dc_response = (w_gnt_valid &&  w_gnt_dc) ? mem2proc_response : 4'd0;

  assign w_ret_valid = (mem2proc_tag != 4'd0) && r_valid[mem2proc_tag];
  assign w_ret_dc    = r_owner[mem2proc_tag];
  assign ic_tag      = (w_ret_valid && !w_ret_dc) ? mem2proc_tag : 4'd0;
  assign dc_tag      = (w_ret_valid &&  w_ret_dc) ? mem2proc_tag : 4'd0;
  assign ret_data    = mem2proc_data;
  assign stray_tag   = r_stray;

  // Owner table, counts, round-robin pointer, lock and stray flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 16'd0;
      r_owner      <= 16'd0;
      r_ic_cnt     <= 4'd0;
      r_dc_cnt     <= 4'd0;
      r_last_grant <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_owner <= 1'b0;
      r_stray      <= 1'b0;
    end else begin
      // Later assignment wins, so a same-tag accept overrides the return clear.
      if (w_ret_valid) r_valid[mem2proc_tag] <= 1'b0;
      if (w_load_acc) begin
        r_valid[mem2proc_response] <= 1'b1;
        r_owner[mem2proc_response] <= w_gnt_dc;
      end
      r_ic_cnt <= cnt_next(r_ic_cnt, w_load_acc && !w_gnt_dc, w_ret_valid && !w_ret_dc);
      r_dc_cnt <= cnt_next(r_dc_cnt, w_load_acc &&  w_gnt_dc, w_ret_valid &&  w_ret_dc);
      r_stray  <= (mem2proc_tag != 4'd0) && !r_valid[mem2proc_tag];
      if (w_accept) r_last_grant <= w_gnt_dc;
      if (w_gnt_valid && (mem2proc_response == 4'd0)) begin
        r_locked     <= 1'b1;
        r_lock_owner <= w_gnt_dc;
      end else if (w_accept) begin
        r_locked <= 1'b0;
      end else if (r_locked && ((r_lock_owner ? dc_command : ic_command) == BUS_NONE)) begin
        r_locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with hand-computed expectations.
// Instance uses MAX_OUTSTANDING = 2 so the cap is reachable in a few loads.
module tb_mem_bus_arbiter;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic        clk;
  logic        reset;
  logic [1:0]  ic_command, dc_command;
  logic [31:0] ic_addr, dc_addr;
  logic [63:0] ic_data, dc_data;
  logic [1:0]  ic_size, dc_size;
  logic [3:0]  ic_response, dc_response, ic_tag, dc_tag;
  logic [63:0] ret_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [1:0]  proc2mem_size;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        stray_tag;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_arbiter #(.MAX_OUTSTANDING(2), .XLEN(32), .SIZE_W(2)) dut (
    .clk(clk), .reset(reset),
    .ic_command(ic_command), .ic_addr(ic_addr), .ic_data(ic_data), .ic_size(ic_size),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data), .dc_size(dc_size),
    .ic_response(ic_response), .dc_response(dc_response),
    .ic_tag(ic_tag), .dc_tag(dc_tag), .ret_data(ret_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag), .stray_tag(stray_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic [1:0] icc, input logic [31:0] ica,
                       input logic [1:0] dcc, input logic [31:0] dca,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdat);
    @(negedge clk);
    ic_command = icc; ic_addr = ica;
    dc_command = dcc; dc_addr = dca;
    mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdat;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    ic_command = NONE; dc_command = NONE;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ic_command = NONE; ic_addr = 32'd0; ic_data = 64'h1111_2222_3333_4444; ic_size = 2'd2;
    dc_command = NONE; dc_addr = 32'd0; dc_data = 64'hAAAA_BBBB_CCCC_DDDD; dc_size = 2'd3;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = 64'd0;

    pulse_reset();
    check("rst_cmd",   proc2mem_command, NONE);
    check("rst_addr",  proc2mem_addr, 32'd0);
    check("rst_icrsp", ic_response, 4'd0);
    check("rst_dcrsp", dc_response, 4'd0);
    check("rst_stray", stray_tag, 1'b0);

    // Round-robin: first tie goes to dcache.
    drive(LOAD, 32'h200, LOAD, 32'h300, 4'd1, 4'd0, 64'd0);
    check("rr1_dcrsp", dc_response, 4'd1);
    check("rr1_icrsp", ic_response, 4'd0);
    check("rr1_addr",  proc2mem_addr, 32'h300);
    check("rr1_size",  proc2mem_size, 2'd3);
    drive(LOAD, 32'h200, LOAD, 32'h300, 4'd2, 4'd0, 64'd0);
    check("rr2_icrsp", ic_response, 4'd2);
    check("rr2_addr",  proc2mem_addr, 32'h200);
    drive(LOAD, 32'h200, LOAD, 32'h300, 4'd3, 4'd0, 64'd0);
    check("rr3_dcrsp", dc_response, 4'd3);
    drive(LOAD, 32'h200, LOAD, 32'h300, 4'd4, 4'd0, 64'd0);
    check("rr4_icrsp", ic_response, 4'd4);
    check("rr4_dcrsp", dc_response, 4'd0);
    // Both at the cap of 2: nothing forwarded.
    drive(LOAD, 32'h200, LOAD, 32'h300, 4'd5, 4'd0, 64'd0);
    check("rr_cap_cmd", proc2mem_command, NONE);
    check("rr_cap_rsp", dc_response, 4'd0);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd2, 64'h22);
    check("ret2_ic", ic_tag, 4'd2);
    check("ret2_dc", dc_tag, 4'd0);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd4, 64'h44);
    check("ret4_ic", ic_tag, 4'd4);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd1, 64'h11);
    check("ret1_dc", dc_tag, 4'd1);
    check("ret1_ic", ic_tag, 4'd0);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd3, 64'h33);
    check("ret3_dc", dc_tag, 4'd3);

    // Single load and return two cycles later.
    drive(NONE, 32'd0, LOAD, 32'h100, 4'd3, 4'd0, 64'd0);
    check("sl_dcrsp", dc_response, 4'd3);
    check("sl_icrsp", ic_response, 4'd0);
    check("sl_cmd",   proc2mem_command, LOAD);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd0, 64'd0);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd3, 64'hDEAD);
    check("sl_dctag", dc_tag, 4'd3);
    check("sl_ictag", ic_tag, 4'd0);
    check("sl_data",  ret_data, 64'hDEAD);

    // Refusal lock: last grant is dcache, so without the lock the tie would go to icache.
    drive(NONE, 32'd0, LOAD, 32'h400, 4'd0, 4'd0, 64'd0);
    check("lk1_addr",  proc2mem_addr, 32'h400);
    check("lk1_dcrsp", dc_response, 4'd0);
    drive(LOAD, 32'h500, LOAD, 32'h400, 4'd0, 4'd0, 64'd0);
    check("lk2_addr",  proc2mem_addr, 32'h400);
    check("lk2_icrsp", ic_response, 4'd0);
    drive(LOAD, 32'h500, LOAD, 32'h400, 4'd0, 4'd0, 64'd0);
    check("lk3_addr",  proc2mem_addr, 32'h400);
    drive(LOAD, 32'h500, LOAD, 32'h400, 4'd5, 4'd0, 64'd0);
    check("lk4_addr",  proc2mem_addr, 32'h400);
    check("lk4_dcrsp", dc_response, 4'd5);
    check("lk4_icrsp", ic_response, 4'd0);

    // Icache cap at 2 outstanding loads.
    drive(LOAD, 32'h600, NONE, 32'd0, 4'd8, 4'd0, 64'd0);
    check("cap1_icrsp", ic_response, 4'd8);
    drive(LOAD, 32'h610, NONE, 32'd0, 4'd9, 4'd0, 64'd0);
    check("cap2_icrsp", ic_response, 4'd9);
    drive(LOAD, 32'h620, NONE, 32'd0, 4'd10, 4'd0, 64'd0);
    check("cap3_cmd",   proc2mem_command, NONE);
    check("cap3_icrsp", ic_response, 4'd0);
    drive(LOAD, 32'h620, NONE, 32'd0, 4'd10, 4'd8, 64'h88);
    check("cap4_cmd",   proc2mem_command, NONE);
    check("cap4_ictag", ic_tag, 4'd8);
    drive(LOAD, 32'h620, NONE, 32'd0, 4'd10, 4'd0, 64'd0);
    check("cap5_cmd",   proc2mem_command, LOAD);
    check("cap5_addr",  proc2mem_addr, 32'h620);
    check("cap5_icrsp", ic_response, 4'd10);
    // Stores are never capped and leave no table entry.
    drive(STORE, 32'h700, NONE, 32'd0, 4'd11, 4'd0, 64'd0);
    check("st_cmd",   proc2mem_command, STORE);
    check("st_data",  proc2mem_data, 64'h1111_2222_3333_4444);
    check("st_icrsp", ic_response, 4'd11);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd9, 64'd0);
    check("ret9_ic", ic_tag, 4'd9);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd10, 64'd0);
    check("ret10_ic", ic_tag, 4'd10);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd5, 64'd0);
    check("ret5_dc", dc_tag, 4'd5);
    check("ret5_stray", stray_tag, 1'b0);

    // Same-cycle reuse of tag 6.
    drive(NONE, 32'd0, LOAD, 32'h800, 4'd6, 4'd0, 64'd0);
    check("ru1_dcrsp", dc_response, 4'd6);
    drive(LOAD, 32'h900, NONE, 32'd0, 4'd6, 4'd6, 64'h66);
    check("ru2_dctag", dc_tag, 4'd6);
    check("ru2_ictag", ic_tag, 4'd0);
    check("ru2_icrsp", ic_response, 4'd6);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd6, 64'h67);
    check("ru3_ictag", ic_tag, 4'd6);
    check("ru3_dctag", dc_tag, 4'd0);

    // Stray from an unrecorded store tag.
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd11, 64'd0);
    check("s11_ictag", ic_tag, 4'd0);
    check("s11_dctag", dc_tag, 4'd0);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd0, 64'd0);
    check("s11_stray", stray_tag, 1'b1);

    // Reset discards in-flight tag 7.
    drive(NONE, 32'd0, LOAD, 32'hA00, 4'd7, 4'd0, 64'd0);
    check("r7_dcrsp", dc_response, 4'd7);
    pulse_reset();
    check("r7_rst_stray", stray_tag, 1'b0);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd7, 64'h77);
    check("r7_ictag", ic_tag, 4'd0);
    check("r7_dctag", dc_tag, 4'd0);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd0, 64'd0);
    check("r7_stray", stray_tag, 1'b1);
    drive(NONE, 32'd0, NONE, 32'd0, 4'd0, 4'd0, 64'd0);
    check("r7_stray_clr", stray_tag, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
